// File: rtl/rf_write_scheduler_pkg.sv
// Shared types for the RF write-port scheduler.
// Register addresses, data words and the LLU holding buffer entry.
package rf_sched_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    xlen_t     data;
  } hold_t;

  function automatic logic is_zero(reg_addr_t a);
    return a == reg_addr_t'(ZERO_REG);
  endfunction
endpackage

// File: rtl/rf_write_scheduler_if.sv
// Bundle between pipeline/LLU and the RF write scheduler.
// Forwarding fields exist only when RFSCHED_FWD_EN is defined.
interface rf_write_scheduler_if;
  import rf_sched_pkg::*;

  logic      wb_we;
  reg_addr_t wb_addr;
  xlen_t     wb_data;
  logic      issue_valid;
  reg_addr_t issue_addr;
  logic      issue_stall;
  logic      llu_valid;
  reg_addr_t llu_addr;
  xlen_t     llu_data;
  logic      llu_ready;
  reg_addr_t id_rs;
  reg_addr_t id_rt;
  logic      hazard_stall;
  logic      starve_stall;
  logic      rf_we;
  reg_addr_t rf_waddr;
  xlen_t     rf_wdata;
  logic [NUM_REGS-1:0] busy_vec;
`ifdef RFSCHED_FWD_EN
  logic      fwd_rs_en;
  logic      fwd_rt_en;
  xlen_t     fwd_data_rs;
  xlen_t     fwd_data_rt;
`endif

  modport master (
    output wb_we, wb_addr, wb_data,
    output issue_valid, issue_addr,
    output llu_valid, llu_addr, llu_data,
    output id_rs, id_rt,
`ifdef RFSCHED_FWD_EN
    input  fwd_rs_en, fwd_rt_en,
    input  fwd_data_rs, fwd_data_rt,
`endif
    input  issue_stall, llu_ready,
    input  hazard_stall, starve_stall,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy_vec
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  issue_valid, issue_addr,
    input  llu_valid, llu_addr, llu_data,
    input  id_rs, id_rt,
`ifdef RFSCHED_FWD_EN
    output fwd_rs_en, fwd_rt_en,
    output fwd_data_rs, fwd_data_rt,
`endif
    output issue_stall, llu_ready,
    output hazard_stall, starve_stall,
    output rf_we, rf_waddr, rf_wdata,
    output busy_vec
  );
endinterface

// File: rtl/rf_write_scheduler_scoreboard.sv
// Pending-LLU-result scoreboard, one bit per register.
// r0 is never tracked; a same-cycle set beats a clear.
module rf_scoreboard
  import rf_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  reg_addr_t           rd_a,
  input  reg_addr_t           rd_b,
  input  reg_addr_t           rd_c,
  output logic                hit_a,
  output logic                hit_b,
  output logic                hit_c,
  output logic [NUM_REGS-1:0] busy_vec
);
  localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] KEEP = ~ONE;

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Decode set/clear requests into one-hot masks.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask = ONE << set_addr;
    if (clr_en) clr_mask = ONE << clr_addr;
  end

  // Apply clear then set so a colliding set survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_vec <= '0;
    else busy_vec <= ((busy_vec & ~clr_mask) | set_mask) & KEEP;
  end

  assign hit_a = busy_vec[rd_a];
  assign hit_b = busy_vec[rd_b];
  assign hit_c = busy_vec[rd_c];
endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the RF write port between WB and a long-latency unit.
// Optional operand forwarding from the buffer: RFSCHED_FWD_EN.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              reset,
  rf_write_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  hold_t            hold;
  logic [CNT_W-1:0] cnt;
  logic             wb_eff;
  logic             drain;
  logic             accept;
  logic             set_en;
  logic             rs_hit;
  logic             rt_hit;
  logic             is_hit;

  assign wb_eff = bus.wb_we && !is_zero(bus.wb_addr);
  assign drain  = hold.valid && !wb_eff;
  assign accept = bus.llu_valid && !hold.valid;
  assign set_en = bus.issue_valid && !bus.issue_stall
               && !is_zero(bus.issue_addr);

  rf_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (bus.issue_addr),
    .clr_en   (drain),
    .clr_addr (hold.addr),
    .rd_a     (bus.id_rs),
    .rd_b     (bus.id_rt),
    .rd_c     (bus.issue_addr),
    .hit_a    (rs_hit),
    .hit_b    (rt_hit),
    .hit_c    (is_hit),
    .busy_vec (bus.busy_vec)
  );

  // Capture one LLU result; release it when a WB slot is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold <= '0;
    else if (accept) hold <= '{valid: 1'b1,
                               addr: bus.llu_addr,
                               data: bus.llu_data};
    else if (drain) hold.valid <= 1'b0;
  end

  // Count cycles the buffer loses arbitration to WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (!hold.valid || drain) cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  // Write port mux, WB first, r0 writes dropped.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    unique case (1'b1)
      wb_eff: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_addr;
        bus.rf_wdata = bus.wb_data;
      end
      (drain && !is_zero(hold.addr)): begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = hold.addr;
        bus.rf_wdata = hold.data;
      end
      default: ;
    endcase
  end

  assign bus.llu_ready    = !hold.valid;
  assign bus.issue_stall  = bus.issue_valid && is_hit;
  assign bus.starve_stall = (cnt == CNT_MAX) && hold.valid;

`ifdef RFSCHED_FWD_EN
  // Buffered operands bypass to ID instead of stalling.
  always_comb begin
    bus.fwd_rs_en   = hold.valid && hold.addr == bus.id_rs
                   && !is_zero(bus.id_rs);
    bus.fwd_rt_en   = hold.valid && hold.addr == bus.id_rt
                   && !is_zero(bus.id_rt);
    bus.fwd_data_rs = hold.data;
    bus.fwd_data_rt = hold.data;
    bus.hazard_stall = (rs_hit && !bus.fwd_rs_en)
                    || (rt_hit && !bus.fwd_rt_en);
  end
`else
  assign bus.hazard_stall = rs_hit || rt_hit;
`endif
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed test for rf_write_scheduler.
// Inputs change 1ns after posedge; outputs checked before next edge.
module tb_rf_write_scheduler;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  rf_write_scheduler_if bus ();

  rf_write_scheduler #(
    .MAX_WAIT (4),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.llu_valid   = 1'b0;
    bus.llu_addr    = '0;
    bus.llu_data    = '0;
    bus.id_rs       = '0;
    bus.id_rt       = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    #2;
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_ready", 32'(bus.llu_ready), 32'd1);
    chk("rst_busy", bus.busy_vec, 32'd0);
    chk("rst_starve", 32'(bus.starve_stall), 32'd0);
    chk("rst_haz", 32'(bus.hazard_stall), 32'd0);
    step();
    reset = 1'b0;
    step();

    // issue r8, result 0x1234, hazard on id_rs=8
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd8;
    #1;
    chk("iss8_stall", 32'(bus.issue_stall), 32'd0);
    step();
    bus.issue_valid = 1'b0;
    bus.id_rs = 5'd8;
    bus.llu_valid = 1'b1;
    bus.llu_addr  = 5'd8;
    bus.llu_data  = 32'h1234;
    #1;
    chk("busy8", bus.busy_vec, 32'h100);
    chk("haz8", 32'(bus.hazard_stall), 32'd1);
    chk("ready8", 32'(bus.llu_ready), 32'd1);
    step();
    bus.llu_valid = 1'b0;
    #1;
    chk("drn8_we", 32'(bus.rf_we), 32'd1);
    chk("drn8_addr", 32'(bus.rf_waddr), 32'd8);
    chk("drn8_data", bus.rf_wdata, 32'h1234);
    chk("drn8_rdy", 32'(bus.llu_ready), 32'd0);
    chk("drn8_haz", 32'(bus.hazard_stall), 32'd1);
    step();
    chk("post8_busy", bus.busy_vec, 32'd0);
    chk("post8_haz", 32'(bus.hazard_stall), 32'd0);
    chk("post8_we", 32'(bus.rf_we), 32'd0);
    chk("post8_rdy", 32'(bus.llu_ready), 32'd1);
    idle();

    // starvation: r9 buffered while WB writes r3
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd9;
    step();
    bus.issue_valid = 1'b0;
    bus.llu_valid = 1'b1;
    bus.llu_addr  = 5'd9;
    bus.llu_data  = 32'h99;
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'h33;
    #1;
    chk("wb3_addr", 32'(bus.rf_waddr), 32'd3);
    step();
    bus.llu_valid = 1'b0;
    #1;
    chk("st0_addr", 32'(bus.rf_waddr), 32'd3);
    chk("st0_data", bus.rf_wdata, 32'h33);
    chk("st0_starve", 32'(bus.starve_stall), 32'd0);
    step();
    step();
    step();
    chk("st3_starve", 32'(bus.starve_stall), 32'd0);
    step();
    chk("st4_starve", 32'(bus.starve_stall), 32'd1);
    chk("st4_busy", bus.busy_vec, 32'h200);
    bus.wb_we = 1'b0;
    #1;
    chk("st_drn_we", 32'(bus.rf_we), 32'd1);
    chk("st_drn_addr", 32'(bus.rf_waddr), 32'd9);
    chk("st_drn_data", bus.rf_wdata, 32'h99);
    step();
    chk("st_end", 32'(bus.starve_stall), 32'd0);
    chk("st_busy", bus.busy_vec, 32'd0);
    idle();

    // WAW on r5 stalls issue
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd5;
    step();
    #1;
    chk("waw_stall", 32'(bus.issue_stall), 32'd1);
    step();
    chk("waw_busy", bus.busy_vec, 32'h20);
    bus.issue_valid = 1'b0;
    bus.llu_valid = 1'b1;
    bus.llu_addr  = 5'd5;
    bus.llu_data  = 32'h55;
    step();
    bus.llu_valid = 1'b0;
    step();
    chk("r5_clr", bus.busy_vec, 32'd0);

    // set beats clear: r5 untracked result drains as r5 issues
    bus.llu_valid = 1'b1;
    bus.llu_addr  = 5'd5;
    bus.llu_data  = 32'h56;
    step();
    bus.llu_valid   = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd5;
    #1;
    chk("sw_stall", 32'(bus.issue_stall), 32'd0);
    chk("sw_waddr", 32'(bus.rf_waddr), 32'd5);
    step();
    bus.issue_valid = 1'b0;
    #1;
    chk("sw_busy", bus.busy_vec, 32'h20);
    bus.llu_valid = 1'b1;
    step();
    bus.llu_valid = 1'b0;
    step();
    chk("sw_clr", bus.busy_vec, 32'd0);
    idle();

    // register 0 writes and issues
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hdead;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd0;
    bus.llu_valid = 1'b1;
    bus.llu_addr  = 5'd0;
    bus.llu_data  = 32'hbeef;
    #1;
    chk("z_wb_we", 32'(bus.rf_we), 32'd0);
    step();
    idle();
    #1;
    chk("z_busy", bus.busy_vec, 32'd0);
    chk("z_drn_we", 32'(bus.rf_we), 32'd0);
    chk("z_rdy0", 32'(bus.llu_ready), 32'd0);
    step();
    chk("z_rdy1", 32'(bus.llu_ready), 32'd1);

    // async reset with a buffered result and r8/r9 pending
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd8;
    step();
    bus.issue_addr  = 5'd9;
    step();
    bus.issue_valid = 1'b0;
    bus.llu_valid = 1'b1;
    bus.llu_addr  = 5'd8;
    bus.llu_data  = 32'h77;
    step();
    bus.llu_valid = 1'b0;
    #1;
    chk("pre_busy", bus.busy_vec, 32'h300);
    chk("pre_rdy", 32'(bus.llu_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("ar_busy", bus.busy_vec, 32'd0);
    chk("ar_rdy", 32'(bus.llu_ready), 32'd1);
    chk("ar_we", 32'(bus.rf_we), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("ar_after", bus.busy_vec, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
